// File: rtl/ifetch_pkg.sv
// ============================================================================
// Module   : ifetch_pkg
// Brief    : Shared types and sizes for the instruction-fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ifetch_pkg;

    localparam int IF_PC_W    = 5;
    localparam int IF_INSTR_W = 32;
    localparam int IF_DEPTH   = 2;
    localparam int CNT_W      = $clog2(IF_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_REDIR = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [IF_INSTR_W-1:0] instr;
        logic [IF_PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifetch_stage_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Brief    : Small power-of-two FIFO with flush; head is read combinationally.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter type T     = fetch_entry_t,
    parameter int  DEPTH = IF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output T                       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T              storage [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot the push is about to use.
    assign do_push = push && (!full || do_pop);
    assign head    = storage[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            storage[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ifetch_stage.sv
// ============================================================================
// Module   : ifetch_stage
// Brief    : Fetch control between PC counter, instruction memory and decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_stage
    import ifetch_pkg::*;
#(
    parameter int PC_W    = IF_PC_W,
    parameter int INSTR_W = IF_INSTR_W,
    parameter int DEPTH   = IF_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    pc,
    output logic               pc_enable,
    output logic               pc_load,
    output logic [PC_W-1:0]    pc_data,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    input  logic               dec_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic              epoch;
    logic              inflight;
    logic [PC_W-1:0]   inflight_pc;
    logic              inflight_epoch;

    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              redir_now;
    logic              issue;
    logic [CW:0]       occupancy;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_FETCH;
            S_REDIR: state_nxt = S_FETCH;
            default: state_nxt = S_IDLE;
        endcase
        if (redirect) begin
            state_nxt = S_REDIR;
        end
    end

    // Slots committed to entries or a pending response; a same-cycle dequeue
    // frees one, which is what sustains one fetch per cycle.
    assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};

    assign redir_now   = redirect && !rst;
    assign issue       = !rst && (state == S_FETCH) && !redirect && !fifo_full
                         && (occupancy < (CW+1)'(DEPTH));
    assign pc_enable   = issue;
    assign imem_req    = issue;
    assign imem_addr   = issue ? pc : '0;
    assign pc_load     = redir_now;
    assign pc_data     = redir_now ? redirect_pc : '0;

    assign instr_valid = !rst && !redirect && !fifo_empty;
    assign instr       = instr_valid ? head_entry.instr : '0;
    assign instr_pc    = instr_valid ? head_entry.pc : '0;
    assign pop         = instr_valid && dec_ready;

    // Responses fetched before the latest redirect carry a stale epoch.
    assign push             = inflight && (inflight_epoch == epoch);
    assign push_entry.instr = imem_rdata;
    assign push_entry.pc    = inflight_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            epoch          <= 1'b0;
            inflight       <= 1'b0;
            inflight_pc    <= '0;
            inflight_epoch <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if (redirect) begin
                epoch <= ~epoch;
            end
            if (issue) begin
                inflight_pc    <= pc;
                inflight_epoch <= epoch;
            end
        end
    end

    fetch_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .head      (head_entry),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

`default_nettype wire
